// File: rtl/addsub_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Number of digit steps needed to cover the full operand width.
   function automatic int ndig(input int width, input int digit);
      return (digit > 0) ? (width / digit) : 1;
   endfunction

   // Digit counter width: $clog2(NDIG), never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple adder slice with carry into its top bit.
module addsub_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout,
   output logic             c_msb
);

   logic [DIGIT:0] full;

   // Digit sum with carry; the carry into the top bit is recovered from the
   // top sum bit, which equals x ^ y ^ carry-in at that position.
   always_comb begin
      full  = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
      sum   = full[DIGIT-1:0];
      cout  = full[DIGIT];
      c_msb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];
   end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial two's-complement adder/subtractor with valid/ready handshakes.
// Optional build macro: ADDSUB_SATURATE_EN clamps s to the signed extreme on
// overflow; without it s wraps modulo 2^WIDTH.
module addsub_serial #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             ovf,
   output logic             cout
);

   import addsub_pkg::*;

   localparam int NDIG = ndig(WIDTH, DIGIT);
   localparam int CW   = cnt_width(NDIG);
   localparam int PW   = (WIDTH > DIGIT) ? (WIDTH - DIGIT) : 1;

   if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("addsub_serial: WIDTH must be >= 2, DIGIT >= 1, WIDTH %% DIGIT == 0");
   end

   state_t           state;
   logic [WIDTH-1:0] areg;
   logic [WIDTH-1:0] breg;
   logic [PW-1:0]    part;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic             dcmsb;
   logic [WIDTH-1:0] snext;
   logic [PW-1:0]    part_next;
   logic [WIDTH-1:0] sfinal;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x     (areg[DIGIT-1:0]),
      .y     (breg[DIGIT-1:0]),
      .cin   (carry),
      .sum   (dsum),
      .cout  (dcout),
      .c_msb (dcmsb)
   );

   // Partial sum keeps only the upper WIDTH-DIGIT bits; the newest digit
   // lands on top and the completed word is assembled with the last digit.
   if (DIGIT < WIDTH) begin : g_multi
      always_comb begin
         snext     = {dsum, part};
         part_next = snext[WIDTH-1:DIGIT];
      end
   end else begin : g_single
      always_comb begin
         snext     = dsum;
         part_next = '0;
      end
   end

   // Final result, optionally clamped; the A sign sits in the top digit here.
   always_comb begin
      sfinal = snext;
`ifdef ADDSUB_SATURATE_EN
      if (dcmsb ^ dcout)
         sfinal = areg[DIGIT-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   // Ready only while idle and out of reset.
   always_comb in_ready = (state == IDLE) && !rst;

   // Control FSM, operand shift registers and registered result outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         areg      <= '0;
         breg      <= '0;
         part      <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
         s         <= '0;
         ovf       <= 1'b0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  areg  <= a;
                  breg  <= b ^ {WIDTH{d}};
                  carry <= d;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               areg  <= areg >> DIGIT;
               breg  <= breg >> DIGIT;
               part  <= part_next;
               carry <= dcout;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(NDIG - 1)) begin
                  s         <= sfinal;
                  ovf       <= dcmsb ^ dcout;
                  cout      <= dcout;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
